// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter onto a single SDRAM request/acknowledge interface.
// Each port buffers one request; the controller sees at most one outstanding access.
module sdram_port_arbiter #(
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        port_rd,
  input  logic [1:0]        port_we,
  input  logic [ADDR_W-1:0] port_addr [2],
  input  logic [7:0]        port_din  [2],
  output logic [7:0]        port_dout [2],
  output logic [1:0]        port_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ack
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]        state_r;
  logic [1:0]        state_nx_s;
  logic              ready_r     [2];
  logic              pend_we_r   [2];
  logic [ADDR_W-1:0] pend_addr_r [2];
  logic [7:0]        pend_din_r  [2];
  logic [7:0]        dout_r      [2];
  logic              grant_r;
  logic              last_grant_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]        mem_din_r;

  logic [1:0]        pending_s;
  logic [1:0]        accept_s;
  logic [1:0]        done_s;
  logic              ack_done_s;
  logic              sel_grant_s;

  assign pending_s  = {~ready_r[1], ~ready_r[0]};
  assign accept_s   = {ready_r[1], ready_r[0]} & (port_rd | port_we);
  assign ack_done_s = (state_r == ST_WAIT) && mem_ack;
  assign done_s     = {ack_done_s & grant_r, ack_done_s & ~grant_r};

  // Round-robin selection: on a tie the port that was not served last wins.
  always_comb begin
    sel_grant_s = 1'b0;
    if (pending_s == 2'b11) begin
      sel_grant_s = ~last_grant_r;
    end else if (pending_s[1]) begin
      sel_grant_s = 1'b1;
    end else begin
      sel_grant_s = 1'b0;
    end
  end

  // Arbiter next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:  state_nx_s = (|pending_s) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_nx_s = ST_WAIT;
      ST_WAIT:  state_nx_s = mem_ack ? ST_IDLE : ST_WAIT;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  for (genvar gp = 0; gp < 2; gp++) begin : g_port
    // Per-port pending slot and returned read data; a busy port ignores strobes.
    always_ff @(posedge clk) begin
      if (reset) begin
        ready_r[gp]     <= 1'b1;
        pend_we_r[gp]   <= 1'b0;
        pend_addr_r[gp] <= '0;
        pend_din_r[gp]  <= 8'h00;
        dout_r[gp]      <= 8'hFF;
      end else if (accept_s[gp]) begin
        ready_r[gp]     <= 1'b0;
        pend_we_r[gp]   <= port_we[gp];
        pend_addr_r[gp] <= port_addr[gp];
        pend_din_r[gp]  <= port_din[gp];
      end else if (done_s[gp]) begin
        ready_r[gp] <= 1'b1;
        if (!pend_we_r[gp]) begin
          dout_r[gp] <= mem_dout;
        end
      end
    end
  end

  // Arbiter state, grant tracking and the registered controller interface.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_din_r    <= 8'h00;
    end else begin
      state_r   <= state_nx_s;
      mem_req_r <= (state_r == ST_IDLE) && (|pending_s);
      case (state_r)
        ST_IDLE: begin
          if (|pending_s) begin
            grant_r    <= sel_grant_s;
            mem_we_r   <= pend_we_r[sel_grant_s];
            mem_addr_r <= pend_addr_r[sel_grant_s];
            mem_din_r  <= pend_din_r[sel_grant_s];
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            last_grant_r <= grant_r;
          end
        end
        default: begin
          last_grant_r <= last_grant_r;
        end
      endcase
    end
  end

  assign port_ready = {ready_r[1], ready_r[0]};
  assign port_dout  = dout_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_din    = mem_din_r;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter with a small controller model.
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 25;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        port_rd;
  logic [1:0]        port_we;
  logic [ADDR_W-1:0] port_addr [2];
  logic [7:0]        port_din  [2];
  logic [7:0]        port_dout [2];
  logic [1:0]        port_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic              mem_ack;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int proto_err = 0;
  logic outstanding = 1'b0;
  logic [7:0] tbmem [logic [ADDR_W-1:0]];

  sdram_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .port_rd(port_rd), .port_we(port_we), .port_addr(port_addr), .port_din(port_din),
    .port_dout(port_dout), .port_ready(port_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Controller-side monitor: counts requests and flags a request while one is outstanding.
  always @(posedge clk) begin
    if (reset) begin
      outstanding <= 1'b0;
    end else if (mem_req) begin
      req_cnt <= req_cnt + 1;
      if (outstanding) proto_err <= proto_err + 1;
      outstanding <= 1'b1;
    end else if (mem_ack) begin
      outstanding <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // Waits for mem_req (bounded), holds for delay cycles, then acks with model data.
  task automatic serve(input int delay, output logic [ADDR_W-1:0] a, output logic w,
                       output logic [7:0] d, output int lat);
    logic hold_ok;
    lat = 0;
    while (mem_req !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL serve_timeout: mem_req=%b required 1", mem_req);
      a = '0; w = 1'b0; d = 8'h00;
      return;
    end
    a = mem_addr; w = mem_we; d = mem_din;
    if (w) tbmem[a] = d;
    hold_ok = 1'b1;
    repeat (delay) begin
      tick();
      if (mem_req !== 1'b0 || mem_addr !== a || mem_we !== w || mem_din !== d) hold_ok = 1'b0;
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL hold: req=%b addr=%h we=%b din=%h required req=0 addr=%h we=%b din=%h",
               mem_req, mem_addr, mem_we, mem_din, a, w, d);
    end
    mem_dout = (!w && tbmem.exists(a)) ? tbmem[a] : 8'h00;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_dout = 8'h00;
  endtask

  task automatic test_reset();
    checks++;
    if (port_ready !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b required 11", port_ready); end
    checks++;
    if (port_dout[0] !== 8'hFF || port_dout[1] !== 8'hFF) begin
      errors++; $display("FAIL reset_dout: got %h/%h required FF/FF", port_dout[0], port_dout[1]);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_din !== 8'h00) begin
      errors++;
      $display("FAIL reset_mem: req=%b we=%b addr=%h din=%h required all 0", mem_req, mem_we, mem_addr, mem_din);
    end
  endtask

  task automatic test_single_read();
    logic [ADDR_W-1:0] a; logic w; logic [7:0] d; int lat; int base;
    base = req_cnt;
    port_rd[1] = 1'b1; port_addr[1] = 25'h0012345;
    tick();
    port_rd[1] = 1'b0;
    checks++;
    if (port_ready !== 2'b01) begin errors++; $display("FAIL sr_busy: ready=%b required 01", port_ready); end
    serve(3, a, w, d, lat);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL sr_latency: got %0d required 1", lat); end
    checks++;
    if (a !== 25'h0012345 || w !== 1'b0) begin
      errors++; $display("FAIL sr_req: addr=%h we=%b required 0012345 0", a, w);
    end
    checks++;
    if (port_dout[1] !== 8'hA5 || port_ready[1] !== 1'b1) begin
      errors++; $display("FAIL sr_done: dout=%h ready=%b required A5 1", port_dout[1], port_ready[1]);
    end
    checks++;
    if (port_dout[0] !== 8'hFF) begin errors++; $display("FAIL sr_other: dout0=%h required FF", port_dout[0]); end
    repeat (3) tick();
    checks++;
    if (req_cnt - base != 1) begin errors++; $display("FAIL sr_count: got %0d required 1", req_cnt - base); end
  endtask

  task automatic test_write_read();
    logic [ADDR_W-1:0] a; logic w; logic [7:0] d; int lat;
    port_we[0] = 1'b1; port_addr[0] = 25'h100; port_din[0] = 8'h3C;
    tick();
    port_we[0] = 1'b0;
    serve(1, a, w, d, lat);
    checks++;
    if (w !== 1'b1 || d !== 8'h3C || a !== 25'h100) begin
      errors++; $display("FAIL wr_req: we=%b din=%h addr=%h required 1 3C 100", w, d, a);
    end
    checks++;
    if (port_dout[0] !== 8'hFF || port_ready[0] !== 1'b1) begin
      errors++; $display("FAIL wr_done: dout0=%h ready0=%b required FF 1", port_dout[0], port_ready[0]);
    end
    // Re-issue right after completion to exercise the minimum turnaround.
    port_rd[0] = 1'b1; port_din[0] = 8'h00;
    tick();
    port_rd[0] = 1'b0;
    serve(1, a, w, d, lat);
    checks++;
    if (lat != 1 || w !== 1'b0 || a !== 25'h100) begin
      errors++; $display("FAIL rd_req: lat=%0d we=%b addr=%h required 1 0 100", lat, w, a);
    end
    checks++;
    if (port_dout[0] !== 8'h3C) begin errors++; $display("FAIL rd_data: dout0=%h required 3C", port_dout[0]); end
  endtask

  task automatic test_contention();
    logic [ADDR_W-1:0] a; logic w; logic [7:0] d; int lat;
    logic [ADDR_W-1:0] exp_a;
    int p;
    apply_reset();
    port_rd = 2'b11; port_addr[0] = 25'h200; port_addr[1] = 25'h300;
    tick();
    port_rd = 2'b00;
    for (int i = 0; i < 8; i++) begin
      serve(1, a, w, d, lat);
      p = i % 2;
      exp_a = (p == 0) ? 25'h200 : 25'h300;
      checks++;
      if (a !== exp_a) begin errors++; $display("FAIL rr_grant%0d: addr=%h required %h", i, a, exp_a); end
      if (i < 6) begin
        port_rd[p] = 1'b1;
        tick();
        port_rd[p] = 1'b0;
      end
    end
    checks++;
    if (port_dout[0] !== 8'h11 || port_dout[1] !== 8'h22 || port_ready !== 2'b11) begin
      errors++;
      $display("FAIL rr_end: dout=%h/%h ready=%b required 11/22 11", port_dout[0], port_dout[1], port_ready);
    end
  endtask

  task automatic test_busy_strobes();
    int base;
    base = req_cnt;
    port_rd[1] = 1'b1; port_addr[1] = 25'h0012345;
    for (int i = 0; i < 6; i++) begin
      tick();
      port_addr[1] = 25'h400 + 25'(i);
    end
    port_rd[1] = 1'b0;
    mem_dout = 8'h5A; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; mem_dout = 8'h00;
    checks++;
    if (port_ready[1] !== 1'b1 || port_dout[1] !== 8'h5A) begin
      errors++; $display("FAIL busy_done: ready1=%b dout1=%h required 1 5A", port_ready[1], port_dout[1]);
    end
    repeat (4) tick();
    checks++;
    if (req_cnt - base != 1) begin errors++; $display("FAIL busy_count: got %0d required 1", req_cnt - base); end
  endtask

  task automatic test_reset_mid_wait();
    int base;
    port_rd[0] = 1'b1; port_addr[0] = 25'h100;
    tick();
    port_rd[0] = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    base = req_cnt;
    checks++;
    if (port_ready !== 2'b11 || port_dout[0] !== 8'hFF || port_dout[1] !== 8'hFF || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait: ready=%b dout=%h/%h req=%b required 11 FF/FF 0",
               port_ready, port_dout[0], port_dout[1], mem_req);
    end
    repeat (2) tick();
    mem_dout = 8'h77; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; mem_dout = 8'h00;
    repeat (3) tick();
    checks++;
    if (port_ready !== 2'b11 || port_dout[0] !== 8'hFF || port_dout[1] !== 8'hFF || req_cnt != base) begin
      errors++;
      $display("FAIL rst_late_ack: ready=%b dout=%h/%h reqs=%0d required 11 FF/FF 0",
               port_ready, port_dout[0], port_dout[1], req_cnt - base);
    end
  endtask

  task automatic test_stray_ack();
    int base;
    base = req_cnt;
    mem_dout = 8'h55; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; mem_dout = 8'h00;
    repeat (2) tick();
    checks++;
    if (port_ready !== 2'b11 || port_dout[0] !== 8'hFF || port_dout[1] !== 8'hFF ||
        mem_req !== 1'b0 || mem_addr !== '0 || req_cnt != base) begin
      errors++;
      $display("FAIL stray_ack: ready=%b dout=%h/%h req=%b addr=%h required 11 FF/FF 0 0",
               port_ready, port_dout[0], port_dout[1], mem_req, mem_addr);
    end
  endtask

  initial begin
    reset = 1'b1; port_rd = 2'b00; port_we = 2'b00;
    port_addr[0] = '0; port_addr[1] = '0; port_din[0] = 8'h00; port_din[1] = 8'h00;
    mem_dout = 8'h00; mem_ack = 1'b0;
    tbmem[25'h0012345] = 8'hA5;
    tbmem[25'h200] = 8'h11;
    tbmem[25'h300] = 8'h22;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_busy_strobes();
    test_reset_mid_wait();
    test_stray_ack();
    checks++;
    if (proto_err != 0) begin errors++; $display("FAIL protocol: overlapping requests=%0d required 0", proto_err); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
